// File: rtl/regfile_write_port.sv
// Write side of the register file: storage, staged write port, one-hot write decoder,
// hardwired zero register and a sequential clear engine.
// Optional forwarding outputs (byp_*) are enabled by defining REGFILE_BYPASS_EN.
module regfile_write_port #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          wr_done,
  input  logic                          clr_req,
  output logic                          busy,
  output logic                          clr_done,
`ifdef REGFILE_BYPASS_EN
  output logic                          byp_valid,
  output logic [ADDR_W-1:0]             byp_addr,
  output logic [WIDTH-1:0]              byp_data,
`endif
  output logic [WIDTH*(2**ADDR_W)-1:0]  q
);

  localparam int                NREG     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(NREG-1);
  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NREG-2);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   clr_idx_r;
  logic                clr_done_r;
  logic                stg_valid_r;
  logic [ADDR_W-1:0]   stg_addr_r;
  logic [WIDTH-1:0]    stg_data_r;
  logic                wr_done_r;
  logic [WIDTH-1:0]    regs_r [NREG-1];
  logic [NREG-1:0]     wr_en_s;
  logic                accept_s;

  // A pending clear request blocks acceptance in the same cycle, so clear wins.
  assign wr_ready = (state_r == IDLE) & ~clr_req & ~reset;
  assign accept_s = wr_valid & wr_ready;
  assign busy     = (state_r == CLEAR);
  assign clr_done = clr_done_r;
  assign wr_done  = wr_done_r;

  // One-hot write enable decoded from the staged address
  always_comb begin
    wr_en_s = '0;
    if (stg_valid_r) begin
      wr_en_s[stg_addr_r] = 1'b1;
    end else begin
      wr_en_s = '0;
    end
  end

  // Clear sequencer: walks indices 0..NREG-2, the zero register needs no clearing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      clr_idx_r  <= '0;
      clr_done_r <= 1'b0;
    end else begin
      clr_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr_req) begin
            state_r   <= CLEAR;
            clr_idx_r <= '0;
          end
        end
        CLEAR: begin
          clr_idx_r <= clr_idx_r + ADDR_W'(1);
          if (clr_idx_r == LAST_CLR) begin
            state_r    <= IDLE;
            clr_done_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          clr_idx_r <= '0;
        end
      endcase
    end
  end

  // Staging register and write-done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid_r <= 1'b0;
      stg_addr_r  <= '0;
      stg_data_r  <= '0;
      wr_done_r   <= 1'b0;
    end else begin
      stg_valid_r <= accept_s;
      wr_done_r   <= |wr_en_s;
      if (accept_s) begin
        stg_addr_r <= wr_addr;
        stg_data_r <= wr_data;
      end
    end
  end

  // Register storage; a clear and a staged write never coincide
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG-1; i++) begin
      if (reset) begin
        regs_r[i] <= '0;
      end else if ((state_r == CLEAR) && (clr_idx_r == ADDR_W'(i))) begin
        regs_r[i] <= '0;
      end else if (wr_en_s[i]) begin
        regs_r[i] <= stg_data_r;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_valid_r;

  // Forwarding valid tracks the staging register but hides zero-register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      byp_valid_r <= 1'b0;
    end else begin
      byp_valid_r <= accept_s & (wr_addr != ZERO_IDX);
    end
  end

  assign byp_valid = byp_valid_r;
  assign byp_addr  = stg_addr_r;
  assign byp_data  = stg_data_r;
`endif

  genvar g;
  for (g = 0; g < NREG-1; g++) begin : g_q
    assign q[g*WIDTH +: WIDTH] = regs_r[g];
  end
  assign q[ZERO_IDX*WIDTH +: WIDTH] = '0;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: reset, table-driven writes, clear and reset-mid-clear.
module tb_regfile_write_port;

  localparam int W    = 64;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            wr_done;
  logic            clr_req;
  logic            busy;
  logic            clr_done;
  logic [W*NREG-1:0] q;
`ifdef REGFILE_BYPASS_EN
  logic            byp_valid;
  logic [AW-1:0]   byp_addr;
  logic [W-1:0]    byp_data;
`endif

  regfile_write_port #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
`ifdef REGFILE_BYPASS_EN
    .byp_valid(byp_valid),
    .byp_addr (byp_addr),
    .byp_data (byp_data),
`endif
    .q        (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t         vecs [6];
  logic [W-1:0] model [NREG];
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole-file comparison against the bench model; reports the first differing slice
  task automatic chk_q(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < NREG; i++) begin
      if (bad < 0 && q[i*W +: W] !== model[i]) bad = i;
    end
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: slice %0d got %h expected %h", name, bad, q[bad*W +: W], model[bad]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
    tick();
    if (a != 5'd31) model[a] = d;
  endtask

  initial begin
    int cnt;
    int rdy_seen;

    vecs[0] = '{5'd3,  64'd1,                   64'd1};
    vecs[1] = '{5'd3,  64'd2,                   64'd2};
    vecs[2] = '{5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[3] = '{5'd0,  64'h0000_0000_0000_00A5, 64'h0000_0000_0000_00A5};
    vecs[4] = '{5'd30, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    vecs[5] = '{5'd31, 64'd5,                   64'd0};
    model_clear();

    // ---- reset ----
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    #1;
    chk("ready_in_reset", {63'd0, wr_ready}, 64'd0);
    tick(); tick();
    chk_q("reset_q");
    chk("reset_busy",     {63'd0, busy},     64'd0);
    chk("reset_wr_done",  {63'd0, wr_done},  64'd0);
    chk("reset_clr_done", {63'd0, clr_done}, 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, wr_ready}, 64'd1);

    // ---- single write: visible two edges after acceptance ----
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    wr_valid = 1'b0;
    chk("single_not_yet_q",    q[5*W +: W],       64'd0);
    chk("single_not_yet_done", {63'd0, wr_done},  64'd0);
    tick();
    model[5] = 64'hDEAD_BEEF_0123_4567;
    chk("single_q5",   q[5*W +: W],      64'hDEAD_BEEF_0123_4567);
    chk("single_done", {63'd0, wr_done}, 64'd1);
    chk_q("single_others");
    tick();
    chk("single_done_drop", {63'd0, wr_done}, 64'd0);

    // ---- table-driven back-to-back writes ----
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      tick();
      if (i > 0) begin
        chk($sformatf("b2b_q[%0d]", i-1), q[vecs[i-1].addr*W +: W], vecs[i-1].exp);
        chk($sformatf("b2b_done[%0d]", i-1), {63'd0, wr_done}, 64'd1);
      end
    end
    wr_valid = 1'b0;
    tick();
    chk("b2b_q[5]",    q[vecs[5].addr*W +: W], vecs[5].exp);
    chk("b2b_done[5]", {63'd0, wr_done}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].addr != 5'd31) model[vecs[i].addr] = vecs[i].data;
    end
    chk_q("b2b_file");
    tick();
    chk("b2b_done_drop", {63'd0, wr_done}, 64'd0);

    // ---- clear with a pending write, concurrent write refused ----
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 64'd7;
    tick();
    clr_req = 1'b1; wr_addr = 5'd4; wr_data = 64'h99;
    #1;
    chk("clr_ready_low", {63'd0, wr_ready}, 64'd0);
    tick();
    clr_req = 1'b0;
    chk("clr_pending_q0", q[0 +: W], 64'd7);
    cnt = 0; rdy_seen = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (wr_ready) rdy_seen++;
      tick();
    end
    wr_valid = 1'b0;
    chk("clr_busy_cycles", 64'(cnt), 64'd31);
    chk("clr_ready_seen",  64'(rdy_seen), 64'd0);
    chk("clr_done_pulse",  {63'd0, clr_done}, 64'd1);
    model_clear();
    chk_q("clr_file");
    tick();
    chk("clr_done_drop",    {63'd0, clr_done}, 64'd0);
    chk("clr_no_2nd_write", {63'd0, wr_done},  64'd0);
    tick();
    chk_q("clr_file_after");

    // ---- held clr_req re-triggers ----
    clr_req = 1'b1;
    tick();
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("retrig_clr_done", {63'd0, clr_done}, 64'd1);
    tick();
    clr_req = 1'b0;
    chk("retrig_busy", {63'd0, busy}, 64'd1);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("retrig_cycles", 64'(cnt), 64'd31);
    tick();

    // ---- reset ten cycles into a clear ----
    do_write(5'd20, 64'h20);
    do_write(5'd7,  64'h77);
    chk_q("pre_abort_file");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    chk("abort_busy",     {63'd0, busy},     64'd0);
    chk("abort_clr_done", {63'd0, clr_done}, 64'd0);
    chk_q("abort_file");
    tick();
    chk("abort_clr_done_next", {63'd0, clr_done}, 64'd0);
    chk("abort_ready",         {63'd0, wr_ready}, 64'd1);

`ifdef REGFILE_BYPASS_EN
    // ---- forwarding outputs ----
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
    tick();
    chk("byp_valid", {63'd0, byp_valid}, 64'd1);
    chk("byp_addr",  {59'd0, byp_addr},  64'd9);
    chk("byp_data",  byp_data,           64'h55);
    wr_addr = 5'd31; wr_data = 64'h66;
    tick();
    wr_valid = 1'b0;
    chk("byp_zero_reg", {63'd0, byp_valid}, 64'd0);
    tick();
    chk("byp_idle", {63'd0, byp_valid}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32x64 ARM register file: storage, 5:32 write decoder, X31 hardwired zero.
- The flattened register contents feed the 32:1 read-mux trees.
- One-entry write staging register with a valid/ready handshake.
- Sequential clear engine that zeroes the file one register per cycle on request.

Parameters:
WIDTH, 64, data width of each register
ADDR_W, 5, address width; register count is 2**ADDR_W; highest index is the zero register

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_valid  input  1  write request present
wr_ready  output  1  write port can accept a request this cycle
wr_addr  input  ADDR_W  destination register index
wr_data  input  WIDTH  write data
wr_done  output  1  one-cycle pulse: committed write now visible on q
clr_req  input  1  request a full-file clear
busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse on clear completion
q  output  WIDTH*2**ADDR_W  flattened register contents; register i occupies q[i*WIDTH +: WIDTH]

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous, active-high, sampled on the `clk` rising edge.
- Reset values:
  - All registers 0.
  - State IDLE; staging valid 0.
  - wr_done=0, clr_done=0, busy=0.
  - wr_ready=0 while reset is high.
- Reset mid-operation: discards any staged write and aborts any clear in progress.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on an edge where clr_req=1.
  - CLEAR -> IDLE on the edge that zeroes index 2**ADDR_W-2.
- Outputs by state:
  - wr_ready = (state==IDLE) & ~clr_req & ~reset. Clear wins over a simultaneous write; that write is not accepted.
  - busy = (state==CLEAR).
- Write handshake:
  - Transfer occurs on an edge with wr_valid & wr_ready; addr/data are captured into the staging register at edge T.
  - The decoded one-hot enable writes the target register at edge T+1.
  - The new value is visible on q, and wr_done=1, in the cycle after T+1.
  - Latency: 2 edges from acceptance to visibility.
- Throughput: one write per cycle; back-to-back writes to the same address commit in order (last wins).
- Zero register (index 2**ADDR_W-1):
  - Writes to it are accepted and still pulse wr_done.
  - The register contents never change; its q slice is constantly 0.
- Decoder: exactly one enable active per committed write; no enable when staging is invalid.
- Clear engine:
  - A staged write captured at edge E-1 still commits at edge E (the edge that enters CLEAR).
  - In CLEAR, the index counter starts at 0 and zeroes register idx at each edge, incrementing.
  - 2**ADDR_W-1 cycles total (31 at default).
  - clr_done pulses for one cycle in the first IDLE cycle after the clear.
  - clr_req is ignored while in CLEAR; wr_valid is ignored (wr_ready=0).
  - After the clear, a held clr_req re-triggers a new clear.
- Read side: q is purely registered; no combinational path from wr_* to q.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, adds outputs:
  - byp_valid (1)
  - byp_addr (ADDR_W)
  - byp_data (WIDTH)
- Bypass outputs mirror the staging register contents: valid, address and data of the write that commits at the next edge.
  - byp_valid is 0 when the staged address is the zero register.
  - byp_valid is 0 after reset.
  - The read stage uses these outputs for forwarding.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert reset 2 cycles -> all q slices 0, wr_ready=0 during reset then 1, busy=0, wr_done=0, clr_done=0.
- Single write: wr_addr=5, wr_data=64'hDEAD_BEEF_0123_4567 accepted at edge T -> q slice 5 equals the data and wr_done=1 in the cycle after T+1; all other slices unchanged.
- Back-to-back writes:
  - addr 3 = 1, addr 3 = 2, addr 31 = 64'hFFFF_FFFF_FFFF_FFFF on consecutive edges.
  - Response: slice 3 shows 1 then 2; slice 31 stays 0; wr_done high 3 consecutive cycles.
- Clear with pending write:
  - Write addr 0 = 7 accepted, then clr_req with wr_valid=1 on the next cycle.
  - Response: wr_ready=0; slice 0 briefly 7 then 0; busy=1 for 31 cycles; clr_done one pulse; all slices 0; second write not accepted.
- Reset mid-clear: reset asserted 10 cycles into CLEAR -> next cycle state IDLE, busy=0, all registers 0, no clr_done pulse.
- Bypass (REGFILE_BYPASS_EN): write addr 9 = 64'h55 accepted at edge T -> byp_valid=1, byp_addr=9, byp_data=64'h55 during the cycle after T; byp_valid=0 for an addr 31 write.
